// File: rtl/hdmi_tmds_period_encoder_if.sv
// Pixel-rate bundle between the island/video sources and the TMDS period encoder.
// The master side drives video, sync and island symbols and receives the three
// TMDS characters; the slave side is the encoder itself.
interface hdmi_tmds_period_encoder_if;
   logic       videoActive;
   logic       hSync;
   logic       vSync;
   logic [7:0] red;
   logic [7:0] green;
   logic [7:0] blue;
   logic       hIslandActive;
   logic [9:0] hIslandCh0;
   logic [9:0] hIslandCh1;
   logic [9:0] hIslandCh2;
   logic       vIslandActive;
   logic [9:0] vIslandCh0;
   logic [9:0] vIslandCh1;
   logic [9:0] vIslandCh2;
   logic [9:0] tmdsCh0;
   logic [9:0] tmdsCh1;
   logic [9:0] tmdsCh2;
   logic       islandConflict;

   modport master (
      output videoActive, hSync, vSync, red, green, blue,
             hIslandActive, hIslandCh0, hIslandCh1, hIslandCh2,
             vIslandActive, vIslandCh0, vIslandCh1, vIslandCh2,
      input  tmdsCh0, tmdsCh1, tmdsCh2, islandConflict
   );

   modport slave (
      input  videoActive, hSync, vSync, red, green, blue,
             hIslandActive, hIslandCh0, hIslandCh1, hIslandCh2,
             vIslandActive, vIslandCh0, vIslandCh1, vIslandCh2,
      output tmdsCh0, tmdsCh1, tmdsCh2, islandConflict
   );
endinterface

// File: rtl/hdmi_tmds_period_encoder.sv
// Final TMDS stage: picks video / guard band / preamble / island / control for
// every character, 8b/10b-encodes video with per-channel running disparity, and
// looks ten characters ahead through a delay line to insert the video lead-in.
module hdmi_tmds_period_encoder #(
   parameter int HDMI_MODE = 1
) (
   input logic                        pixelClock,
   input logic                        resetN,
   hdmi_tmds_period_encoder_if.slave  bus
);

   localparam bit HDMI_ON = (HDMI_MODE != 0);

   localparam logic [9:0] CTL_00 = 10'b1101010100;
   localparam logic [9:0] CTL_01 = 10'b0010101011;
   localparam logic [9:0] CTL_10 = 10'b0101010100;
   localparam logic [9:0] CTL_11 = 10'b1010101011;
   localparam logic [9:0] GUARD_CH02 = 10'b1011001100;
   localparam logic [9:0] GUARD_CH1  = 10'b0100110011;

   typedef struct packed {
      logic       de;
      logic       hSync;
      logic       vSync;
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
      logic       hIslandActive;
      logic [9:0] hIslandCh0;
      logic [9:0] hIslandCh1;
      logic [9:0] hIslandCh2;
      logic       vIslandActive;
      logic [9:0] vIslandCh0;
      logic [9:0] vIslandCh1;
      logic [9:0] vIslandCh2;
   } slotT;

   typedef enum logic [2:0] {
      PERIOD_CONTROL,
      PERIOD_VIDEO,
      PERIOD_GUARD,
      PERIOD_PREAMBLE,
      PERIOD_HISLAND,
      PERIOD_VISLAND
   } periodT;

   typedef struct packed {
      logic [9:0]        code;
      logic signed [4:0] disparity;
   } tmdsResultT;

   function automatic logic [9:0] ctlCode(input logic [1:0] c);
      case (c)
         2'b00:   ctlCode = CTL_00;
         2'b01:   ctlCode = CTL_01;
         2'b10:   ctlCode = CTL_10;
         default: ctlCode = CTL_11;
      endcase
   endfunction

   // DVI 1.0 video encode; balance is (ones - zeros) of the minimised byte.
   function automatic tmdsResultT tmdsEncode(input logic [7:0] d, input logic signed [4:0] cnt);
      logic              useXnor;
      logic [8:0]        qm;
      logic [3:0]        onesQm;
      logic signed [5:0] wideBalance;
      logic signed [4:0] balance;
      tmdsResultT        r;
      useXnor = (4'($countones(d)) > 4'd4) || ((4'($countones(d)) == 4'd4) && !d[0]);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         qm[i] = useXnor ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
      end
      qm[8] = ~useXnor;
      onesQm = 4'($countones(qm[7:0]));
      wideBalance = $signed({1'b0, onesQm, 1'b0}) - 6'sd8;
      balance = wideBalance[4:0];
      if ((cnt == 5'sd0) || (balance == 5'sd0)) begin
         r.code = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
         r.disparity = qm[8] ? (cnt + balance) : (cnt - balance);
      end else if (((cnt > 5'sd0) && (balance > 5'sd0)) || ((cnt < 5'sd0) && (balance < 5'sd0))) begin
         r.code = {1'b1, qm[8], ~qm[7:0]};
         r.disparity = cnt + (qm[8] ? 5'sd2 : 5'sd0) - balance;
      end else begin
         r.code = {1'b0, qm[8], qm[7:0]};
         r.disparity = cnt - (qm[8] ? 5'sd0 : 5'sd2) + balance;
      end
      return r;
   endfunction

   slotT              incoming;
   slotT              delayLine [10];
   slotT              current;
   logic [9:0]        deAhead;
   periodT            period;
   logic              conflictNext;
   logic signed [4:0] disparity0, disparity1, disparity2;
   tmdsResultT        enc0, enc1, enc2;
   logic [9:0]        ch0Q, ch1Q, ch2Q;
   logic              conflictQ;

   // Pack the live inputs into one delay-line slot.
   always_comb begin
      incoming.de            = bus.videoActive;
      incoming.hSync         = bus.hSync;
      incoming.vSync         = bus.vSync;
      incoming.red           = bus.red;
      incoming.green         = bus.green;
      incoming.blue          = bus.blue;
      incoming.hIslandActive = bus.hIslandActive;
      incoming.hIslandCh0    = bus.hIslandCh0;
      incoming.hIslandCh1    = bus.hIslandCh1;
      incoming.hIslandCh2    = bus.hIslandCh2;
      incoming.vIslandActive = bus.vIslandActive;
      incoming.vIslandCh0    = bus.vIslandCh0;
      incoming.vIslandCh1    = bus.vIslandCh1;
      incoming.vIslandCh2    = bus.vIslandCh2;
   end

   assign current = delayLine[9];

   // Look-ahead: deAhead[k-1] is videoActive of character n+k, k = 1..10.
   always_comb begin
      deAhead[9] = incoming.de;
      for (int k = 0; k < 9; k++) begin
         deAhead[k] = delayLine[8-k].de;
      end
   end

   // Priority selection of the period type for the character leaving the delay line.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      period       = PERIOD_CONTROL;
      conflictNext = 1'b0;
      if (current.de) begin
         period = PERIOD_VIDEO;
      end else if (HDMI_ON && (|deAhead[1:0])) begin
         period = PERIOD_GUARD;
      end else if (HDMI_ON && (|deAhead[9:2])) begin
         period = PERIOD_PREAMBLE;
      end else if (HDMI_ON && current.hIslandActive) begin
         period = PERIOD_HISLAND;
      end else if (HDMI_ON && current.vIslandActive) begin
         period = PERIOD_VISLAND;
      end
      if (HDMI_ON) begin
         conflictNext = (current.hIslandActive && current.vIslandActive) ||
                        ((current.hIslandActive || current.vIslandActive) &&
                         (period inside {PERIOD_VIDEO, PERIOD_GUARD, PERIOD_PREAMBLE}));
      end
   end

   // Video encoders for blue (ch0), green (ch1) and red (ch2).
   always_comb begin
      enc0 = tmdsEncode(current.blue,  disparity0);
      enc1 = tmdsEncode(current.green, disparity1);
      enc2 = tmdsEncode(current.red,   disparity2);
   end

   // Delay line, disparity state and registered TMDS characters.
   always_ff @(posedge pixelClock) begin
      if (!resetN) begin
         // NOTE: the delay line is explicitly cleared so the characters after reset are clean control.
         for (int i = 0; i < 10; i++) begin
            delayLine[i] <= '0;
         end
         disparity0 <= '0;
         disparity1 <= '0;
         disparity2 <= '0;
         ch0Q       <= CTL_00;
         ch1Q       <= CTL_00;
         ch2Q       <= CTL_00;
         conflictQ  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make the shift read every stage's old value.
         delayLine[0] <= incoming;
         for (int i = 1; i < 10; i++) begin
            delayLine[i] <= delayLine[i-1];
         end
         conflictQ  <= conflictNext;
         disparity0 <= '0;
         disparity1 <= '0;
         disparity2 <= '0;
         unique case (period)
            PERIOD_VIDEO: begin
               ch0Q       <= enc0.code;
               ch1Q       <= enc1.code;
               ch2Q       <= enc2.code;
               disparity0 <= enc0.disparity;
               disparity1 <= enc1.disparity;
               disparity2 <= enc2.disparity;
            end
            PERIOD_GUARD: begin
               ch0Q <= GUARD_CH02;
               ch1Q <= GUARD_CH1;
               ch2Q <= GUARD_CH02;
            end
            PERIOD_PREAMBLE: begin
               ch0Q <= ctlCode({current.vSync, current.hSync});
               ch1Q <= CTL_01;
               ch2Q <= CTL_00;
            end
            PERIOD_HISLAND: begin
               ch0Q <= current.hIslandCh0;
               ch1Q <= current.hIslandCh1;
               ch2Q <= current.hIslandCh2;
            end
            PERIOD_VISLAND: begin
               ch0Q <= current.vIslandCh0;
               ch1Q <= current.vIslandCh1;
               ch2Q <= current.vIslandCh2;
            end
            default: begin
               ch0Q <= ctlCode({current.vSync, current.hSync});
               ch1Q <= CTL_00;
               ch2Q <= CTL_00;
            end
         endcase
      end
   end

   assign bus.tmdsCh0        = ch0Q;
   assign bus.tmdsCh1        = ch1Q;
   assign bus.tmdsCh2        = ch2Q;
   assign bus.islandConflict = conflictQ;

endmodule

// File: tb/tb_hdmi_tmds_period_encoder.sv
// Bench for hdmi_tmds_period_encoder: an HDMI-mode and a DVI-mode instance see
// identical directed stimulus; a reference model fills per-instance scoreboards.
module tb_hdmi_tmds_period_encoder;

   logic pixelClock = 1'b0;
   logic resetN     = 1'b0;
   always #5 pixelClock = ~pixelClock;

   hdmi_tmds_period_encoder_if busH ();
   hdmi_tmds_period_encoder_if busD ();

   hdmi_tmds_period_encoder #(.HDMI_MODE(1)) dutH (.pixelClock(pixelClock), .resetN(resetN), .bus(busH));
   hdmi_tmds_period_encoder #(.HDMI_MODE(0)) dutD (.pixelClock(pixelClock), .resetN(resetN), .bus(busD));

   typedef struct packed {
      bit       de, hs, vs;
      bit [7:0] r, g, b;
      bit       ha;
      bit [9:0] h0, h1, h2;
      bit       va;
      bit [9:0] v0, v1, v2;
   } slotT;

   typedef struct packed {
      logic [9:0] c0, c1, c2;
      logic       cf;
   } expT;

   slotT hist [11];
   int   disp [2][3];
   expT  qH [$];
   expT  qD [$];
   int   total = 0;
   int   bad   = 0;

   // Drive state applied on every tick.
   bit       rstDrv, deDrv, hsDrv, vsDrv, haDrv, vaDrv, randomPix;
   bit [7:0] rDrv, gDrv, bDrv;
   bit [9:0] h0Drv, h1Drv, h2Drv, v0Drv, v1Drv, v2Drv;

   function automatic bit [9:0] ctl(input bit [1:0] c);
      case (c)
         2'b00:   return 10'b1101010100;
         2'b01:   return 10'b0010101011;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   // Reference TMDS encoder written straight from the DVI 1.0 flow chart.
   function automatic void refEncode(input bit [7:0] d, input int cntIn, output bit [9:0] q, output int cntOut);
      int     ones, n1, n0;
      bit     xn;
      bit [8:0] qm;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i] ^ xn;
      qm[8] = !xn;
      n1 = 0;
      for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
      n0 = 8 - n1;
      cntOut = cntIn;
      if (cntIn == 0 || n1 == n0) begin
         q = {!qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
         if (qm[8]) cntOut = cntIn + (n1 - n0);
         else       cntOut = cntIn + (n0 - n1);
      end else if ((cntIn > 0 && n1 > n0) || (cntIn < 0 && n0 > n1)) begin
         q = {1'b1, qm[8], ~qm[7:0]};
         cntOut = cntIn + 2 * int'(qm[8]) + (n0 - n1);
      end else begin
         q = {1'b0, qm[8], qm[7:0]};
         cntOut = cntIn - 2 * (1 - int'(qm[8])) + (n1 - n0);
      end
   endfunction

   // Expected character leaving the pipeline; idx 0 = HDMI instance, 1 = DVI.
   task automatic modelChar(input int idx, output expT e);
      slotT     c;
      bit       m, nearDe, farDe;
      bit [9:0] q;
      int       nc;
      m = (idx == 0);
      c = hist[10];
      nearDe = hist[9].de | hist[8].de;
      farDe = 1'b0;
      for (int k = 3; k <= 10; k++) farDe |= hist[10-k].de;
      e.cf = 1'b0;
      if (c.de) begin
         refEncode(c.b, disp[idx][0], q, nc); e.c0 = q; disp[idx][0] = nc;
         refEncode(c.g, disp[idx][1], q, nc); e.c1 = q; disp[idx][1] = nc;
         refEncode(c.r, disp[idx][2], q, nc); e.c2 = q; disp[idx][2] = nc;
         e.cf = m & (c.ha | c.va);
      end else begin
         for (int ch = 0; ch < 3; ch++) disp[idx][ch] = 0;
         if (m && nearDe) begin
            e.c0 = 10'b1011001100; e.c1 = 10'b0100110011; e.c2 = 10'b1011001100;
            e.cf = c.ha | c.va;
         end else if (m && farDe) begin
            e.c0 = ctl({c.vs, c.hs}); e.c1 = ctl(2'b01); e.c2 = ctl(2'b00);
            e.cf = c.ha | c.va;
         end else if (m && c.ha) begin
            e.c0 = c.h0; e.c1 = c.h1; e.c2 = c.h2;
            e.cf = c.va;
         end else if (m && c.va) begin
            e.c0 = c.v0; e.c1 = c.v1; e.c2 = c.v2;
         end else begin
            e.c0 = ctl({c.vs, c.hs}); e.c1 = ctl(2'b00); e.c2 = ctl(2'b00);
         end
      end
   endtask

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply the drive state for n cycles, scoring every output character.
   task automatic tick(input int n);
      expT  e;
      slotT s;
      for (int i = 0; i < n; i++) begin
         @(negedge pixelClock);
         if (randomPix) begin
            rDrv = 8'($urandom); gDrv = 8'($urandom); bDrv = 8'($urandom);
         end
         resetN = rstDrv;
         busH.videoActive = deDrv; busH.hSync = hsDrv; busH.vSync = vsDrv;
         busH.red = rDrv; busH.green = gDrv; busH.blue = bDrv;
         busH.hIslandActive = haDrv; busH.hIslandCh0 = h0Drv; busH.hIslandCh1 = h1Drv; busH.hIslandCh2 = h2Drv;
         busH.vIslandActive = vaDrv; busH.vIslandCh0 = v0Drv; busH.vIslandCh1 = v1Drv; busH.vIslandCh2 = v2Drv;
         busD.videoActive = deDrv; busD.hSync = hsDrv; busD.vSync = vsDrv;
         busD.red = rDrv; busD.green = gDrv; busD.blue = bDrv;
         busD.hIslandActive = haDrv; busD.hIslandCh0 = h0Drv; busD.hIslandCh1 = h1Drv; busD.hIslandCh2 = h2Drv;
         busD.vIslandActive = vaDrv; busD.vIslandCh0 = v0Drv; busD.vIslandCh1 = v1Drv; busD.vIslandCh2 = v2Drv;
         if (!rstDrv) begin
            for (int k = 0; k < 11; k++) hist[k] = '0;
            for (int k = 0; k < 3; k++) begin disp[0][k] = 0; disp[1][k] = 0; end
            e = {ctl(2'b00), ctl(2'b00), ctl(2'b00), 1'b0};
            qH.push_back(e);
            qD.push_back(e);
         end else begin
            for (int k = 10; k > 0; k--) hist[k] = hist[k-1];
            s = {deDrv, hsDrv, vsDrv, rDrv, gDrv, bDrv, haDrv, h0Drv, h1Drv, h2Drv, vaDrv, v0Drv, v1Drv, v2Drv};
            hist[0] = s;
            modelChar(0, e); qH.push_back(e);
            modelChar(1, e); qD.push_back(e);
         end
         @(posedge pixelClock);
         #1;
         e = qH.pop_front();
         check("hdmi_ch0", busH.tmdsCh0, e.c0);
         check("hdmi_ch1", busH.tmdsCh1, e.c1);
         check("hdmi_ch2", busH.tmdsCh2, e.c2);
         check("hdmi_conflict", {9'b0, busH.islandConflict}, {9'b0, e.cf});
         e = qD.pop_front();
         check("dvi_ch0", busD.tmdsCh0, e.c0);
         check("dvi_ch1", busD.tmdsCh1, e.c1);
         check("dvi_ch2", busD.tmdsCh2, e.c2);
         check("dvi_conflict", {9'b0, busD.islandConflict}, {9'b0, e.cf});
      end
   endtask

   initial begin
      rstDrv = 0; deDrv = 0; hsDrv = 0; vsDrv = 0; haDrv = 0; vaDrv = 0; randomPix = 0;
      rDrv = 0; gDrv = 0; bDrv = 0;
      h0Drv = 10'h2AA; h1Drv = 10'h155; h2Drv = 10'h333;
      v0Drv = 10'h0F0; v1Drv = 10'h3C3; v2Drv = 10'h1E1;

      // Reset, then hSync high during blanking.
      tick(3);
      rstDrv = 1; hsDrv = 1;
      tick(14);
      hsDrv = 0; vsDrv = 1;
      tick(12);
      vsDrv = 0;

      // Three blue=0 pixels, a one-character gap, the same three again.
      deDrv = 1; rDrv = 8'h10; gDrv = 8'hA5; bDrv = 8'h00;
      tick(3);
      deDrv = 0;
      tick(1);
      deDrv = 1;
      tick(3);
      deDrv = 0;
      tick(12);

      // Random active line with syncs set during the lead-in.
      hsDrv = 1; vsDrv = 1;
      tick(2);
      deDrv = 1; randomPix = 1;
      tick(20);
      deDrv = 0; randomPix = 0;
      tick(3);
      deDrv = 1;
      tick(2);
      deDrv = 0; hsDrv = 0; vsDrv = 0;
      tick(14);

      // HBlank island alone, then overlapping VBlank island, then VBlank alone.
      haDrv = 1;
      tick(4);
      vaDrv = 1;
      tick(3);
      haDrv = 0;
      tick(3);
      vaDrv = 0;
      tick(12);

      // Island still active as video starts and runs.
      haDrv = 1;
      tick(3);
      deDrv = 1; bDrv = 8'hFF; gDrv = 8'h0F; rDrv = 8'h80;
      tick(2);
      haDrv = 0;
      tick(4);
      deDrv = 0;
      tick(12);

      // One-clock reset in the middle of an active line.
      deDrv = 1; randomPix = 1;
      tick(6);
      rstDrv = 0;
      tick(1);
      rstDrv = 1; randomPix = 0; rDrv = 8'h00; gDrv = 8'h00; bDrv = 8'h00;
      tick(14);
      deDrv = 0;
      tick(12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
